// File: rtl/counting_bloom.sv
// Counting Bloom filter: insert/delete/check/clear over saturating counters,
// hash indices applied serially one per clock behind a valid/ready command/response pair.
module counting_bloom #(
    parameter int unsigned D_SIZE   = 8,
    parameter int unsigned BL_SIZE  = 32,
    parameter int unsigned NUM_HASH = 3,
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned ELEM_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op,
    input  logic [D_SIZE:0]   data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              match,
    output logic              resp_err,
    output logic              resp_sat,
    output logic [ELEM_W-1:0] elem_count
);

    localparam int unsigned IDX_W  = $clog2(BL_SIZE);
    localparam int unsigned STEP_W = ((IDX_W > 3) ? IDX_W : 3) + 1;
    localparam int unsigned KEY_W  = D_SIZE + 1;
    localparam int unsigned PROD_W = KEY_W + 5;

    localparam logic [CNT_W-1:0]  SAT      = {CNT_W{1'b1}};
    localparam logic [ELEM_W-1:0] ELEM_MAX = {ELEM_W{1'b1}};

    localparam logic [1:0] OP_INS = 2'b00;
    localparam logic [1:0] OP_DEL = 2'b01;
    localparam logic [1:0] OP_CHK = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PROBE,
        S_UPDATE,
        S_CLEAR,
        S_RESP
    } state_t;

    state_t              r_state,      w_state_nxt;
    logic [STEP_W-1:0]   r_step,       w_step_nxt;
    logic [1:0]          r_op,         w_op_nxt;
    logic [KEY_W-1:0]    r_data,       w_data_nxt;
    logic                r_acc,        w_acc_nxt;
    logic                r_hit_sat,    w_hit_sat_nxt;
    logic                r_resp_valid, w_resp_valid_nxt;
    logic                r_match,      w_match_nxt;
    logic                r_err,        w_err_nxt;
    logic                r_sat,        w_sat_nxt;
    logic [ELEM_W-1:0]   r_elem,       w_elem_nxt;

    logic [CNT_W-1:0]    r_cnt [BL_SIZE];

    logic [PROD_W-1:0]   w_prod;
    logic [IDX_W-1:0]    w_idx;
    logic [CNT_W-1:0]    w_rd;
    logic                w_probe_ok;
    logic                w_last;
    logic                w_we;
    logic [IDX_W-1:0]    w_widx;
    logic [CNT_W-1:0]    w_wdata;

    // Hash j = r_step: full-width product, then keep the low IDX_W bits
    assign w_prod     = PROD_W'(r_data) * (PROD_W'(r_step) * PROD_W'(2) + PROD_W'(3))
                        + PROD_W'(r_step);
    assign w_idx      = w_prod[IDX_W-1:0];
    assign w_rd       = r_cnt[w_idx];
    assign w_probe_ok = r_acc & (w_rd != '0);
    assign w_last     = (r_step == STEP_W'(NUM_HASH - 1));

    assign in_ready   = (r_state == S_IDLE) & reset;
    assign resp_valid = r_resp_valid;
    assign match      = r_match;
    assign resp_err   = r_err;
    assign resp_sat   = r_sat;
    assign elem_count = r_elem;

    always_comb begin
        w_state_nxt      = r_state;
        w_step_nxt       = r_step;
        w_op_nxt         = r_op;
        w_data_nxt       = r_data;
        w_acc_nxt        = r_acc;
        w_hit_sat_nxt    = r_hit_sat;
        w_resp_valid_nxt = r_resp_valid;
        w_match_nxt      = r_match;
        w_err_nxt        = r_err;
        w_sat_nxt        = r_sat;
        w_elem_nxt       = r_elem;
        w_we             = 1'b0;
        w_widx           = w_idx;
        w_wdata          = '0;

        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_op_nxt      = op;
                    w_data_nxt    = data;
                    w_step_nxt    = '0;
                    w_acc_nxt     = 1'b1;
                    w_hit_sat_nxt = 1'b0;
                    case (op)
                        OP_INS:  w_state_nxt = S_UPDATE;
                        OP_CLR:  w_state_nxt = S_CLEAR;
                        default: w_state_nxt = S_PROBE;
                    endcase
                end
            end
            S_PROBE: begin
                w_acc_nxt  = w_probe_ok;
                w_step_nxt = r_step + STEP_W'(1);
                if (w_last) begin
                    w_step_nxt = '0;
                    if (r_op == OP_CHK) begin
                        w_state_nxt      = S_RESP;
                        w_resp_valid_nxt = 1'b1;
                        w_match_nxt      = w_probe_ok;
                    end else if (w_probe_ok) begin
                        w_state_nxt = S_UPDATE;
                    end else begin
                        w_state_nxt      = S_RESP;
                        w_resp_valid_nxt = 1'b1;
                        w_err_nxt        = 1'b1;
                    end
                end
            end
            S_UPDATE: begin
                w_we       = 1'b1;
                w_step_nxt = r_step + STEP_W'(1);
                if (r_op == OP_INS) begin
                    w_hit_sat_nxt = r_hit_sat | (w_rd == SAT);
                    w_wdata       = (w_rd == SAT) ? SAT : w_rd + CNT_W'(1);
                end else begin
                    // saturated counters are sticky; floor at zero guards duplicate indices
                    w_wdata = ((w_rd == SAT) || (w_rd == '0)) ? w_rd : w_rd - CNT_W'(1);
                end
                if (w_last) begin
                    w_step_nxt       = '0;
                    w_state_nxt      = S_RESP;
                    w_resp_valid_nxt = 1'b1;
                    if (r_op == OP_INS) begin
                        w_sat_nxt  = w_hit_sat_nxt;
                        w_elem_nxt = (r_elem == ELEM_MAX) ? r_elem : r_elem + ELEM_W'(1);
                    end else begin
                        w_elem_nxt = (r_elem == '0) ? r_elem : r_elem - ELEM_W'(1);
                    end
                end
            end
            S_CLEAR: begin
                w_we       = 1'b1;
                w_widx     = r_step[IDX_W-1:0];
                w_wdata    = '0;
                w_step_nxt = r_step + STEP_W'(1);
                if (r_step == STEP_W'(BL_SIZE - 1)) begin
                    w_step_nxt       = '0;
                    w_state_nxt      = S_RESP;
                    w_resp_valid_nxt = 1'b1;
                    w_elem_nxt       = '0;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    w_state_nxt      = S_IDLE;
                    w_resp_valid_nxt = 1'b0;
                    w_match_nxt      = 1'b0;
                    w_err_nxt        = 1'b0;
                    w_sat_nxt        = 1'b0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Control and response registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_step       <= '0;
            r_op         <= '0;
            r_data       <= '0;
            r_acc        <= 1'b0;
            r_hit_sat    <= 1'b0;
            r_resp_valid <= 1'b0;
            r_match      <= 1'b0;
            r_err        <= 1'b0;
            r_sat        <= 1'b0;
            r_elem       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_step       <= w_step_nxt;
            r_op         <= w_op_nxt;
            r_data       <= w_data_nxt;
            r_acc        <= w_acc_nxt;
            r_hit_sat    <= w_hit_sat_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_match      <= w_match_nxt;
            r_err        <= w_err_nxt;
            r_sat        <= w_sat_nxt;
            r_elem       <= w_elem_nxt;
        end
    end

    // Counter array: single write port driven by the FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(BL_SIZE); i++) begin
                r_cnt[i] <= '0;
            end
        end else if (w_we) begin
            r_cnt[w_widx] <= w_wdata;
        end
    end

endmodule
